// File: rtl/gpu_pkg.sv
// gpu_pkg: shared warp-dispatch types and descriptor field widths
package gpu_pkg;
    localparam int WARP_SIZE_DEF = 32;
    localparam int TID_W = 32;
    localparam int BID_W = 32;
    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, DRAIN, DONE} state_e;
endpackage

// File: rtl/warp_slot_tracker.sv
// warp_slot_tracker: slot occupancy, lowest-free slot select and retire counting
module warp_slot_tracker #(
    parameter int N = 4,
    parameter int SLOT_W = 2,
    parameter int RCNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en_i,
    input  logic [SLOT_W-1:0] alloc_slot_i,
    input  logic [N-1:0]      warp_retire_i,
    output logic [N-1:0]      slot_busy_o,
    output logic [SLOT_W-1:0] free_slot_o,
    output logic              any_free_o,
    output logic [RCNT_W-1:0] retire_cnt_o
);
    logic [N-1:0] busy_q, busy_d, ret_v;

    always_comb begin
        ret_v = warp_retire_i & busy_q;
        busy_d = busy_q & ~ret_v;
        if (alloc_en_i) busy_d[alloc_slot_i] = 1'b1;
        retire_cnt_o = '0;
        free_slot_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            retire_cnt_o = retire_cnt_o + RCNT_W'(ret_v[i]);
            if (!busy_q[i]) free_slot_o = SLOT_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) busy_q <= '0;
        else busy_q <= busy_d;

    assign slot_busy_o = busy_q;
    assign any_free_o = ~&busy_q;
endmodule

// File: rtl/warp_dispatch.sv
// warp_dispatch: splits a dispatched thread block into warps, issues them to
// free warp slots and reports block completion once every warp has retired.
module warp_dispatch
    import gpu_pkg::*;
#(
    parameter int NUM_WARP_SLOTS = 4,
    parameter int WARP_SIZE = WARP_SIZE_DEF,
    parameter int MAX_BLOCK_DIM = 1024
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         block_start,
    input  logic [BID_W-1:0]                             block_id,
    input  logic [31:0]                                  num_threads,
    input  logic [31:0]                                  block_dim,
    output logic                                         block_done,
    output logic                                         warp_valid,
    input  logic                                         warp_ready,
    output logic [$clog2(NUM_WARP_SLOTS)-1:0]            warp_slot,
    output logic [$clog2(MAX_BLOCK_DIM/WARP_SIZE)-1:0]   warp_idx,
    output logic [BID_W-1:0]                             warp_block_id,
    output logic [TID_W-1:0]                             warp_base_tid,
    output logic [WARP_SIZE-1:0]                         warp_mask,
    input  logic [NUM_WARP_SLOTS-1:0]                    warp_retire,
    output logic [NUM_WARP_SLOTS-1:0]                    slot_busy
);
    localparam int SLOT_W = $clog2(NUM_WARP_SLOTS);
    localparam int WID_W = $clog2(MAX_BLOCK_DIM / WARP_SIZE);
    localparam int CNT_W = WID_W + 1;
    localparam int LANE_W = $clog2(WARP_SIZE);
    localparam int RCNT_W = $clog2(NUM_WARP_SLOTS + 1);

    state_e              state_q;
    logic [BID_W-1:0]    bid_q;
    logic [TID_W-1:0]    base_q;
    logic [CNT_W-1:0]    nwarps_q, issued_q, retired_q, nwarps_w;
    logic [LANE_W-1:0]   rem_q;
    logic                done_q, stall_q, hs, any_free, last;
    logic [SLOT_W-1:0]   hold_slot_q, free_slot, slot_c;
    logic [RCNT_W-1:0]   retire_cnt;
    logic [31:0]         avail, tib_raw, tib_sat;

    warp_slot_tracker #(.N(NUM_WARP_SLOTS), .SLOT_W(SLOT_W), .RCNT_W(RCNT_W)) u_trk (
        .clk          (clk),
        .rst          (rst),
        .alloc_en_i   (hs),
        .alloc_slot_i (slot_c),
        .warp_retire_i(warp_retire),
        .slot_busy_o  (slot_busy),
        .free_slot_o  (free_slot),
        .any_free_o   (any_free),
        .retire_cnt_o (retire_cnt)
    );

    always_comb begin
        avail = num_threads - base_q;
        tib_raw = (base_q >= num_threads) ? 32'd0 : (block_dim < avail ? block_dim : avail);
        tib_sat = (tib_raw > 32'(MAX_BLOCK_DIM)) ? 32'(MAX_BLOCK_DIM) : tib_raw;
        nwarps_w = CNT_W'((tib_sat + 32'(WARP_SIZE - 1)) >> LANE_W);
    end

    // A stalled offer keeps its slot so the descriptor stays stable even if a
    // lower slot frees up while waiting for ready.
    assign slot_c = stall_q ? hold_slot_q : free_slot;
    assign warp_valid = (state_q == ISSUE) && (issued_q < nwarps_q) && any_free;
    assign hs = warp_valid && warp_ready;
    assign last = issued_q == nwarps_q - CNT_W'(1);
    assign warp_slot = warp_valid ? slot_c : '0;
    assign warp_idx = warp_valid ? issued_q[WID_W-1:0] : '0;
    assign warp_block_id = warp_valid ? bid_q : '0;
    assign warp_base_tid = warp_valid ? base_q + (TID_W'(issued_q) << LANE_W) : '0;
    assign warp_mask = !warp_valid ? '0 :
                       (last && rem_q != '0) ? (WARP_SIZE'(1) << rem_q) - WARP_SIZE'(1) : '1;
    assign block_done = done_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            bid_q <= '0;
            base_q <= '0;
            nwarps_q <= '0;
            issued_q <= '0;
            retired_q <= '0;
            rem_q <= '0;
            done_q <= 1'b0;
            stall_q <= 1'b0;
            hold_slot_q <= '0;
        end else begin
            retired_q <= retired_q + CNT_W'(retire_cnt);
            stall_q <= warp_valid && !warp_ready;
            hold_slot_q <= slot_c;
            case (state_q)
                IDLE:
                    if (block_start) begin
                        bid_q <= block_id;
                        base_q <= block_id * block_dim;
                        state_q <= SETUP;
                    end
                SETUP: begin
                    nwarps_q <= nwarps_w;
                    rem_q <= tib_sat[LANE_W-1:0];
                    issued_q <= '0;
                    retired_q <= '0;
                    state_q <= (nwarps_w == '0) ? DONE : ISSUE;
                    done_q <= nwarps_w == '0;
                end
                ISSUE:
                    if (hs) begin
                        issued_q <= issued_q + CNT_W'(1);
                        if (issued_q + CNT_W'(1) == nwarps_q) state_q <= DRAIN;
                    end
                DRAIN:
                    if (retired_q == nwarps_q) begin
                        state_q <= DONE;
                        done_q <= 1'b1;
                    end
                DONE:
                    if (!block_start) begin
                        state_q <= IDLE;
                        done_q <= 1'b0;
                    end
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_warp_dispatch.sv
// tb_warp_dispatch: scoreboard bench; a block-level model queues expected warps,
// a monitor checks every offered warp, slot choice and occupancy.
module tb_warp_dispatch;
    logic        clk = 0, rst = 1, block_start = 0, warp_ready = 0;
    logic [31:0] block_id = 0, num_threads = 0, block_dim = 0;
    logic        block_done, warp_valid;
    logic [1:0]  warp_slot;
    logic [4:0]  warp_idx;
    logic [31:0] warp_block_id, warp_base_tid, warp_mask;
    logic [3:0]  warp_retire = 0, slot_busy;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] tid;
        logic [31:0] mask;
        logic [31:0] bid;
    } warp_t;

    warp_t        exp_q[$];
    logic [3:0]   mdl_busy = 0;
    int           mdl_retired = 0, mdl_nw = 0;
    bit           prev_stall = 0, rdy_rand = 0, ret_rand = 0;
    logic [1:0]   held_slot = 0;
    logic [127:0] prev_out = 0;
    int           checks = 0, errors = 0;

    warp_dispatch dut (
        .clk(clk), .rst(rst), .block_start(block_start), .block_id(block_id),
        .num_threads(num_threads), .block_dim(block_dim), .block_done(block_done),
        .warp_valid(warp_valid), .warp_ready(warp_ready), .warp_slot(warp_slot),
        .warp_idx(warp_idx), .warp_block_id(warp_block_id), .warp_base_tid(warp_base_tid),
        .warp_mask(warp_mask), .warp_retire(warp_retire), .slot_busy(slot_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] lowest_free(logic [3:0] b);
        for (int i = 0; i < 4; i++) if (!b[i]) return 2'(i);
        return 2'd0;
    endfunction

    always @(negedge clk) begin
        logic [1:0] es;
        warp_t e;
        es = 0;
        if (rst) prev_stall = 0;
        else begin
            chk("slot_busy", slot_busy, mdl_busy);
            if (block_done) chk("done_early", 128'(mdl_retired == mdl_nw && exp_q.size() == 0), 1);
            if (prev_stall)
                chk("stall_held", {warp_valid, warp_idx, warp_base_tid, warp_mask, warp_block_id, warp_slot}, prev_out);
            if (warp_valid) begin
                chk("valid_has_free", 128'(mdl_busy != 4'hf), 1);
                es = prev_stall ? held_slot : lowest_free(mdl_busy);
                chk("warp_slot", warp_slot, es);
                if (exp_q.size() == 0) chk("warp_valid_extra", warp_valid, 0);
                else begin
                    e = exp_q[0];
                    chk("warp_idx", warp_idx, e.idx);
                    chk("warp_base_tid", warp_base_tid, e.tid);
                    chk("warp_mask", warp_mask, e.mask);
                    chk("warp_block_id", warp_block_id, e.bid);
                    if (warp_ready) void'(exp_q.pop_front());
                end
            end
            mdl_retired += $countones(warp_retire & mdl_busy);
            mdl_busy = (mdl_busy & ~warp_retire) | ((warp_valid && warp_ready) ? 4'(1 << es) : 4'h0);
            prev_stall = warp_valid && !warp_ready;
            held_slot = es;
            prev_out = {warp_valid, warp_idx, warp_base_tid, warp_mask, warp_block_id, warp_slot};
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) warp_ready = 1'($urandom_range(0, 1));
        if (ret_rand) warp_retire = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand(bit rdy, bit ret);
        rdy_rand = rdy;
        ret_rand = ret;
        if (!ret) warp_retire = 0;
    endtask

    task automatic start_block(int unsigned bid, int unsigned nt, int unsigned bd);
        logic [31:0] base, tib, lanes;
        warp_t e;
        base = bid * bd;
        tib = (base >= nt) ? 0 : ((nt - base < bd) ? nt - base : bd);
        if (tib > 1024) tib = 1024;
        mdl_nw = int'((tib + 31) / 32);
        mdl_retired = 0;
        for (int w = 0; w < mdl_nw; w++) begin
            lanes = tib - 32 * w;
            if (lanes > 32) lanes = 32;
            e.idx = 5'(w);
            e.tid = base + 32 * w;
            e.mask = (lanes == 32) ? 32'hFFFF_FFFF : (32'd1 << lanes) - 1;
            e.bid = bid;
            exp_q.push_back(e);
        end
        block_id = bid;
        num_threads = nt;
        block_dim = bd;
        block_start = 1;
    endtask

    task automatic finish_block(int hold);
        int n = 0;
        while (!block_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", block_done, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("retired_all", mdl_retired, mdl_nw);
        repeat (hold) begin
            @(negedge clk);
            chk("done_hold", block_done, 1);
        end
        tick();
        block_start = 0;
        @(negedge clk);
        chk("done_until_seen_low", block_done, 1);
        @(negedge clk);
        chk("done_clear", block_done, 0);
        chk("idle_no_valid", warp_valid, 0);
    endtask

    task automatic wait_busy(logic [3:0] v);
        int n = 0;
        while (slot_busy !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_busy", slot_busy, v);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_done", block_done, 0);
        chk("rst_valid", warp_valid, 0);
        chk("rst_busy", slot_busy, 0);
        chk("rst_outs", {warp_slot, warp_idx, warp_block_id, warp_base_tid, warp_mask}, 0);
        tick();
        rst = 0;

        warp_ready = 1;
        tick();
        start_block(1, 100, 64);
        wait_busy(4'b0011);
        tick(); warp_retire = 4'b0001;
        tick(); warp_retire = 0;
        @(negedge clk);
        chk("t1_partial_retire", slot_busy, 4'b0010);
        tick(); warp_retire = 4'b0010;
        tick(); warp_retire = 0;
        finish_block(2);

        tick();
        start_block(3, 64, 64);
        @(negedge clk);
        @(negedge clk);
        chk("t4_setup_done", block_done, 0);
        @(negedge clk);
        chk("t4_done_2cyc", block_done, 1);
        chk("t4_no_valid", warp_valid, 0);
        finish_block(3);

        tick();
        start_block(0, 1024, 256);
        wait_busy(4'hf);
        chk("t2_full_no_valid", warp_valid, 0);
        tick(); warp_retire = 4'b0100;
        tick(); warp_retire = 0;
        @(negedge clk);
        chk("t2_reissue_valid", warp_valid, 1);
        chk("t2_reissue_slot", warp_slot, 2);
        chk("t2_reissue_idx", warp_idx, 4);
        set_rand(0, 1);
        finish_block(1);
        set_rand(0, 0);

        warp_ready = 0;
        tick();
        start_block(2, 1024, 256);
        for (int n = 0; n < 20 && !warp_valid; n++) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("t3_stall_valid", warp_valid, 1);
            chk("t3_stall_idx", warp_idx, 0);
            chk("t3_stall_busy", slot_busy, 0);
        end
        set_rand(1, 1);
        finish_block(0);
        set_rand(0, 0);

        warp_ready = 1;
        tick();
        start_block(5, 400, 64);
        wait_busy(4'b0011);
        tick(); warp_retire = 4'b1111;
        tick(); warp_retire = 0;
        @(negedge clk);
        chk("t5_all_cleared", slot_busy, 0);
        finish_block(1);

        set_rand(1, 1);
        tick();
        start_block(0, 1024, 256);
        repeat (5) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("t6_rst_valid", warp_valid, 0);
        chk("t6_rst_busy", slot_busy, 0);
        chk("t6_rst_done", block_done, 0);
        chk("t6_rst_outs", {warp_slot, warp_idx, warp_block_id, warp_base_tid, warp_mask}, 0);
        block_start = 0;
        exp_q.delete();
        mdl_busy = 0;
        tick();
        rst = 0;
        tick();
        start_block(7, 1000, 128);
        finish_block(1);

        for (int k = 0; k < 20; k++) begin
            tick();
            start_block($urandom_range(0, 20), $urandom_range(0, 3000), $urandom_range(1, 256));
            finish_block($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
